fpu_wb_queue: RTL and testbench
===============================

Name: fpu_wb_queue

Overview:
- Sits directly upstream of writeback, on one lane (upper or lower); one instance per lane.
- Several FPU units (fadd, fsub, fmul, fsqrt, fdiv, ftoi, itof) can finish in the same cycle. This block captures every completing result so none is lost.
- It drains the captured results to writeback as one register-write per cycle, in order.
- It also gives issue logic a pending-destination bitmap and an almost-full stall.

Parameters:
- NSRC, 4, number of FPU result sources merged (1..8).
- DEPTH, 8, queue entries; power of two, at least NSRC.
- AF_MARGIN, NSRC, stall_issue asserts when free entries ≤ AF_MARGIN.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- interlock  in  1  pipeline hold; 1 = writeback is not consuming this cycle.
- src_valid  in  NSRC  per-source result-valid (FPU rt_flag).
- src_rt  in  5*NSRC  per-source destination register; source i at [5i+4:5i].
- src_tdata  in  32*NSRC  per-source result; source i at [32i+31:32i].
- out_valid  out  1  a head entry is available for writeback.
- out_rt  out  5  head entry destination.
- out_tdata  out  32  head entry data.
- pending  out  32  bit r = 1 when any queued entry targets register r.
- stall_issue  out  1  registered almost-full indication to issue logic.
- count  out  $clog2(DEPTH)+1  current occupancy.
- overflow  out  1  sticky error flag, cleared only by rst.

Behaviour:
- Storage: circular buffer of DEPTH entries {rt, tdata}, with rd_ptr and wr_ptr of width $clog2(DEPTH). Pointers wrap modulo DEPTH.
- Reset (rst=1 at a clock edge):
  - rd_ptr, wr_ptr and count go to 0; stall_issue and overflow go to 0.
  - Entry data is not cleared. out_valid=0 and pending=0 follow from count=0.
  - Reset mid-operation discards all queued entries. Sources valid in the reset cycle are ignored.
- Push:
  - Each cycle, let k = number of set src_valid bits.
  - Valid sources are written at wr_ptr, wr_ptr+1, … in ascending source index (source 0 first).
  - wr_ptr advances by the number accepted.
- Pop: pop = out_valid & ~interlock. A pop advances rd_ptr by 1.
- Next occupancy: count_next = count − pop + accepted.
- Free space: free = DEPTH − count + pop. A same-cycle pop frees its slot for pushes in that cycle.
- Overflow:
  - If k > free, the lowest-index free sources are accepted.
  - The remaining sources are dropped and overflow is set to 1 (sticky).
  - The queue never exceeds DEPTH.
- Outputs:
  - out_valid = (count ≠ 0). out_rt and out_tdata are the entry at rd_ptr.
  - All three are combinational from registered state; no input-to-output paths.
  - Latency: a result pushed in cycle N is visible at the output in cycle N+1 at the earliest.
  - No bypass: with the queue empty, pushes in cycle N are not visible in cycle N.
- Ordering: strictly FIFO. Program order between sources in the same cycle is ascending index.
  - Two queued entries with the same rt are both delivered, the older first.
- Interlock: while interlock=1, out_* hold their values and there is no pop. Pushes still proceed, since FPU pipelines are not stalled by this block.
- pending:
  - The OR, over the occupied entries between rd_ptr and wr_ptr, of the one-hot decode of each entry's rt.
  - Combinational from registered state.
  - Entries pushed this cycle appear in the next cycle; the popped entry clears in the next cycle.
- stall_issue: registered, computed as (DEPTH − count_next) ≤ AF_MARGIN.
- count: wraps never; its range is 0..DEPTH.

Test Plan:
- Reset, then single push: src_valid=0001, rt=5, data=0x3F800000 in cycle 1 -> cycle 2 out_valid=1, out_rt=5, out_tdata=0x3F800000, pending=0x20; with interlock=0, cycle 3 out_valid=0 and pending=0.
- Simultaneous sources: src_valid=1011 with rt 1,2,4 (sources 0,1,3) and data 0xA,0xB,0xD in one cycle -> drains in three consecutive cycles as (1,0xA),(2,0xB),(4,0xD); count is 3,2,1,0.
- Interlock hold: queue holds 2 entries and interlock=1 for 4 cycles while 1 source pushes each cycle -> out_* stay constant, count goes 2→6, stall_issue=1 once free ≤ 4; after release the entries drain in FIFO order.
- Full with same-cycle pop: count=8, interlock=0, src_valid=0001 -> entry is accepted, count stays 8, overflow stays 0. Then interlock=1 and src_valid=0011 with count=8 -> both sources dropped, overflow=1 and remains 1 until rst.
- Wrap-around: push and pop 20 single entries with increasing data 0..19 -> output sequence is 0..19 exactly, with pointers wrapping twice.
- Reset mid-operation: count=5 and rst asserted for one cycle with src_valid=1111 -> next cycle count=0, out_valid=0, pending=0, overflow=0.

Source files
------------

// File: rtl/fpu_wb_queue.sv
// fpu_wb_queue: merges same-cycle FPU results into a FIFO draining one register write per cycle to writeback
module fpu_wb_queue #(
    parameter int NSRC      = 4,
    parameter int DEPTH     = 8,
    parameter int AF_MARGIN = NSRC
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     interlock,
    input  logic [NSRC-1:0]          src_valid,
    input  logic [5*NSRC-1:0]        src_rt,
    input  logic [32*NSRC-1:0]       src_tdata,
    output logic                     out_valid,
    output logic [4:0]               out_rt,
    output logic [31:0]              out_tdata,
    output logic [31:0]              pending,
    output logic                     stall_issue,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [4:0]    mem_rt   [DEPTH];
    logic [31:0]   mem_data [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [AW-1:0] waddr [NSRC];
    logic [NSRC-1:0] wen;
    logic [CW-1:0] free, acc, count_next;
    logic          pop, drop;

    assign out_valid  = count != '0;
    assign out_rt     = mem_rt[rd_ptr];
    assign out_tdata  = mem_data[rd_ptr];
    assign pop        = out_valid & ~interlock;
    assign free       = CW'(DEPTH) - count + CW'(pop);
    assign count_next = count - CW'(pop) + acc;

    always_comb begin
        acc  = '0;
        drop = 1'b0;
        for (int i = 0; i < NSRC; i++) begin
            wen[i]   = src_valid[i] && (acc < free);
            waddr[i] = wr_ptr + acc[AW-1:0];
            drop     = drop | (src_valid[i] & ~wen[i]);
            acc      = acc + CW'(wen[i]);
        end
    end

    always_comb begin
        pending = '0;
        for (int j = 0; j < DEPTH; j++)
            if ({1'b0, AW'(AW'(j) - rd_ptr)} < count) pending[mem_rt[j]] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            stall_issue <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            rd_ptr      <= rd_ptr + AW'(pop);
            wr_ptr      <= wr_ptr + acc[AW-1:0];
            count       <= count_next;
            stall_issue <= (CW'(DEPTH) - count_next) <= CW'(AF_MARGIN);
            overflow    <= overflow | drop;
            for (int i = 0; i < NSRC; i++)
                if (wen[i]) begin
                    mem_rt[waddr[i]]   <= src_rt[5*i +: 5];
                    mem_data[waddr[i]] <= src_tdata[32*i +: 32];
                end
        end
    end
endmodule

// File: tb/tb_fpu_wb_queue.sv
// tb_fpu_wb_queue: directed self-checking bench for fpu_wb_queue
module tb_fpu_wb_queue;
    logic         clk = 1'b0;
    logic         rst, interlock;
    logic [3:0]   src_valid;
    logic [19:0]  src_rt;
    logic [127:0] src_tdata;
    logic         out_valid, stall_issue, overflow;
    logic [4:0]   out_rt;
    logic [31:0]  out_tdata, pending;
    logic [3:0]   count;
    int tests = 0;
    int fails = 0;

    fpu_wb_queue dut (
        .clk(clk), .rst(rst), .interlock(interlock), .src_valid(src_valid),
        .src_rt(src_rt), .src_tdata(src_tdata), .out_valid(out_valid),
        .out_rt(out_rt), .out_tdata(out_tdata), .pending(pending),
        .stall_issue(stall_issue), .count(count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic src(input int i, input logic [4:0] rt, input logic [31:0] d);
        src_valid[i]        = 1'b1;
        src_rt[5*i +: 5]    = rt;
        src_tdata[32*i +: 32] = d;
    endtask

    initial begin
        logic [4:0]  exp_rt [6];
        logic [31:0] exp_d  [8];
        rst = 1'b1; interlock = 1'b0; src_valid = '0; src_rt = '0; src_tdata = '0;
        tick(); tick();
        rst = 1'b0;
        chk("reset_count", 32'(count), 0);
        chk("reset_valid", 32'(out_valid), 0);
        chk("reset_pending", pending, 0);
        chk("reset_stall", 32'(stall_issue), 0);
        chk("reset_overflow", 32'(overflow), 0);

        src(0, 5'd5, 32'h3F80_0000);
        #1 chk("no_bypass", 32'(out_valid), 0);
        tick(); src_valid = '0;
        chk("single_valid", 32'(out_valid), 1);
        chk("single_rt", 32'(out_rt), 5);
        chk("single_data", out_tdata, 32'h3F80_0000);
        chk("single_pending", pending, 32'h20);
        tick();
        chk("single_drained", 32'(out_valid), 0);
        chk("single_pending_clr", pending, 0);

        src(0, 5'd1, 32'hA); src(1, 5'd2, 32'hB); src(3, 5'd4, 32'hD);
        tick(); src_valid = '0;
        chk("multi_pending", pending, 32'h16);
        chk("multi_count0", 32'(count), 3);
        chk("multi_rt0", 32'(out_rt), 1);
        chk("multi_d0", out_tdata, 32'hA);
        tick();
        chk("multi_count1", 32'(count), 2);
        chk("multi_rt1", 32'(out_rt), 2);
        chk("multi_d1", out_tdata, 32'hB);
        tick();
        chk("multi_count2", 32'(count), 1);
        chk("multi_rt2", 32'(out_rt), 4);
        chk("multi_d2", out_tdata, 32'hD);
        tick();
        chk("multi_count3", 32'(count), 0);

        interlock = 1'b1;
        src(0, 5'd7, 32'h70); src(1, 5'd8, 32'h80);
        tick(); src_valid = '0;
        chk("il_count", 32'(count), 2);
        for (int n = 0; n < 4; n++) begin
            src(0, 5'(10 + n), 32'h100 + n);
            tick();
            chk("il_count_grow", 32'(count), 3 + n);
            chk("il_rt_hold", 32'(out_rt), 7);
            chk("il_data_hold", out_tdata, 32'h70);
            chk("il_stall", 32'(stall_issue), (n >= 1) ? 1 : 0);
        end
        src_valid = '0; interlock = 1'b0;
        exp_rt = '{5'd7, 5'd8, 5'd10, 5'd11, 5'd12, 5'd13};
        for (int n = 0; n < 6; n++) begin
            chk("il_drain_rt", 32'(out_rt), 32'(exp_rt[n]));
            tick();
        end
        chk("il_drain_count", 32'(count), 0);
        chk("il_drain_stall", 32'(stall_issue), 0);

        interlock = 1'b1;
        for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < 4; i++) src(i, 5'(4*b + i), 32'(4*b + i));
            tick();
        end
        src_valid = '0;
        chk("full_count", 32'(count), 8);
        chk("full_stall", 32'(stall_issue), 1);
        interlock = 1'b0;
        src(0, 5'd20, 32'h99);
        tick(); src_valid = '0;
        chk("full_pop_push_count", 32'(count), 8);
        chk("full_pop_push_ovf", 32'(overflow), 0);
        interlock = 1'b1;
        src(0, 5'd21, 32'h55); src(1, 5'd22, 32'h66);
        tick(); src_valid = '0;
        chk("full_drop_count", 32'(count), 8);
        chk("full_drop_ovf", 32'(overflow), 1);
        interlock = 1'b0;
        exp_d = '{32'h1, 32'h2, 32'h3, 32'h4, 32'h5, 32'h6, 32'h7, 32'h99};
        for (int n = 0; n < 8; n++) begin
            chk("full_drain_data", out_tdata, exp_d[n]);
            tick();
        end
        chk("full_drain_count", 32'(count), 0);
        chk("ovf_sticky", 32'(overflow), 1);
        rst = 1'b1; tick(); rst = 1'b0;
        chk("ovf_cleared", 32'(overflow), 0);

        for (int n = 0; n < 20; n++) begin
            src(0, 5'(n), 32'(n));
            tick();
            chk("wrap_data", out_tdata, 32'(n));
            chk("wrap_count", 32'(count), 1);
        end
        src_valid = '0;
        tick();
        chk("wrap_empty", 32'(count), 0);

        interlock = 1'b1;
        for (int i = 0; i < 4; i++) src(i, 5'(i), 32'(i));
        tick(); src_valid = '0;
        src(0, 5'd9, 32'h9);
        tick(); src_valid = '0;
        chk("rst_mid_count5", 32'(count), 5);
        rst = 1'b1;
        for (int i = 0; i < 4; i++) src(i, 5'(i + 16), 32'(i));
        tick(); rst = 1'b0; src_valid = '0;
        chk("rst_mid_count", 32'(count), 0);
        chk("rst_mid_valid", 32'(out_valid), 0);
        chk("rst_mid_pending", pending, 0);
        chk("rst_mid_ovf", 32'(overflow), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
